// File: rtl/otsu_binarize.sv
// Purpose: binarize an 8-bit gray video stream against a frame-synchronous Otsu threshold and count foreground pixels per frame.
// Latency: fixed 2 clocks from iGray/hs/vs/de to oBin/oGray/ohs/ovs/ode; oFg_valid follows the output ovs rise by one clock.
// Backpressure: none; one pixel accepted every clock, no bubbles inserted.
module otsu_binarize #(
  parameter int unsigned DEFAULT_THR = 128,
  parameter bit          INVERT      = 1'b0
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic [7:0]  iGray,
  input  logic        hs,
  input  logic        vs,
  input  logic        de,
  input  logic [7:0]  iThresh,
  input  logic        iThresh_valid,
  output logic        oBin,
  output logic [7:0]  oGray,
  output logic        ohs,
  output logic        ovs,
  output logic        ode,
  output logic [7:0]  oThr_active,
  output logic [23:0] oFg_cnt,
  output logic        oFg_valid
);

  localparam logic [7:0]  DEF_THR = 8'(DEFAULT_THR);
  localparam logic [23:0] CNT_MAX = 24'hFF_FFFF;

  // Input-side frame boundary detection
  logic        vs_d;
  logic        vs_rise;

  // Threshold staging: pending value waits for the next frame start
  logic [7:0]  thr_act;
  logic [7:0]  thr_pend;
  logic        pend_vld;

  // Pixel pipeline stage 1
  logic [7:0]  gray_s1;
  logic        hs_s1;
  logic        vs_s1;
  logic        de_s1;
  logic        bin_s1;

  // Output-side frame accounting
  logic        ovs_d;
  logic        ovs_rise;
  logic        fg_pix;
  logic        seen_frame;
  logic [23:0] fg_acc;

  assign vs_rise     = vs & ~vs_d;
  assign ovs_rise    = ovs & ~ovs_d;
  assign fg_pix      = ode & oBin;
  assign oThr_active = thr_act;

  // Registered copy of vs so a frame start is seen as a 0->1 transition
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      vs_d <= 1'b0;
    end else begin
      vs_d <= vs;
    end
  end

  // Threshold update: strobes park in pending, promoted only at frame start;
  // a strobe landing exactly on the frame start goes straight to active
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      thr_act  <= DEF_THR;
      thr_pend <= DEF_THR;
      pend_vld <= 1'b0;
    end else if (vs_rise) begin
      if (iThresh_valid) begin
        thr_act <= iThresh;
      end else if (pend_vld) begin
        thr_act <= thr_pend;
      end
      pend_vld <= 1'b0;
    end else if (iThresh_valid) begin
      thr_pend <= iThresh;
      pend_vld <= 1'b1;
    end
  end

  // Stage 1: register pixel and timing; the compare then sees the threshold
  // already updated by a frame start occurring on this pixel
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      gray_s1 <= 8'd0;
      hs_s1   <= 1'b0;
      vs_s1   <= 1'b0;
      de_s1   <= 1'b0;
    end else begin
      gray_s1 <= iGray;
      hs_s1   <= hs;
      vs_s1   <= vs;
      de_s1   <= de;
    end
  end

  // Binary decision: strict greater-than, optional inversion, blanked outside de
  always_comb begin
    bin_s1 = 1'b0;
    if (de_s1) begin
      bin_s1 = (gray_s1 > thr_act) ^ INVERT;
    end
  end

  // Stage 2: output registers, timing kept aligned with the decision
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      oBin  <= 1'b0;
      oGray <= 8'h00;
      ohs   <= 1'b0;
      ovs   <= 1'b0;
      ode   <= 1'b0;
    end else begin
      oBin  <= bin_s1;
      oGray <= {8{bin_s1}};
      ohs   <= hs_s1;
      ovs   <= vs_s1;
      ode   <= de_s1;
    end
  end

  // Output-side frame boundary detection
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      ovs_d <= 1'b0;
    end else begin
      ovs_d <= ovs;
    end
  end

  // Foreground counter: saturating, restarted at each output frame start
  // (including the pixel coincident with that start)
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      fg_acc <= 24'd0;
    end else if (ovs_rise) begin
      fg_acc <= {23'd0, fg_pix};
    end else if (fg_pix && (fg_acc != CNT_MAX)) begin
      fg_acc <= fg_acc + 24'd1;
    end
  end

  // Frame result publication; the first frame start after reset closes only
  // a partial frame, so it arms publication instead of reporting
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      seen_frame <= 1'b0;
      oFg_cnt    <= 24'd0;
      oFg_valid  <= 1'b0;
    end else begin
      oFg_valid <= 1'b0;
      if (ovs_rise) begin
        seen_frame <= 1'b1;
        if (seen_frame) begin
          oFg_cnt   <= fg_acc;
          oFg_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_otsu_binarize.sv
// Purpose: directed, table-driven checks of otsu_binarize (INVERT=0 and INVERT=1 instances side by side).
// Latency: expects outputs 2 clocks after inputs; frame results one clock after the output vs rise.
// Backpressure: none; stimulus is driven on falling edges, outputs sampled on falling edges.
module tb_otsu_binarize;

  logic        clock;
  logic        rst_n;
  logic [7:0]  iGray;
  logic        hs;
  logic        vs;
  logic        de;
  logic [7:0]  iThresh;
  logic        iThresh_valid;

  logic        oBin,        oBin_i;
  logic [7:0]  oGray,       oGray_i;
  logic        ohs,         ohs_i;
  logic        ovs,         ovs_i;
  logic        ode,         ode_i;
  logic [7:0]  oThr_active, oThr_active_i;
  logic [23:0] oFg_cnt,     oFg_cnt_i;
  logic        oFg_valid,   oFg_valid_i;

  int total = 0;
  int bad   = 0;

  int          pulses   = 0;
  int          pulses_i = 0;
  logic [23:0] last_cnt   = '0;
  logic [23:0] last_cnt_i = '0;

  typedef struct {
    logic [7:0] gray;
    logic       de;
    logic       exp_bin;
    logic       exp_inv;
  } tv_t;

  localparam int NV = 269;
  tv_t tbl [0:NV-1];

  otsu_binarize #(.DEFAULT_THR(128), .INVERT(1'b0)) u_dut (
    .clock(clock), .rst_n(rst_n), .iGray(iGray), .hs(hs), .vs(vs), .de(de),
    .iThresh(iThresh), .iThresh_valid(iThresh_valid),
    .oBin(oBin), .oGray(oGray), .ohs(ohs), .ovs(ovs), .ode(ode),
    .oThr_active(oThr_active), .oFg_cnt(oFg_cnt), .oFg_valid(oFg_valid)
  );

  otsu_binarize #(.DEFAULT_THR(128), .INVERT(1'b1)) u_inv (
    .clock(clock), .rst_n(rst_n), .iGray(iGray), .hs(hs), .vs(vs), .de(de),
    .iThresh(iThresh), .iThresh_valid(iThresh_valid),
    .oBin(oBin_i), .oGray(oGray_i), .ohs(ohs_i), .ovs(ovs_i), .ode(ode_i),
    .oThr_active(oThr_active_i), .oFg_cnt(oFg_cnt_i), .oFg_valid(oFg_valid_i)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Frame-result monitor
  always @(negedge clock) begin
    if (oFg_valid) begin
      pulses   = pulses + 1;
      last_cnt = oFg_cnt;
    end
    if (oFg_valid_i) begin
      pulses_i   = pulses_i + 1;
      last_cnt_i = oFg_cnt_i;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic set_tv(input int idx, input logic [7:0] g, input logic d,
                        input logic b, input logic bi);
    tbl[idx].gray    = g;
    tbl[idx].de      = d;
    tbl[idx].exp_bin = b;
    tbl[idx].exp_inv = bi;
  endtask

  task automatic step(input logic [7:0] g, input logic h, input logic v, input logic d,
                      input logic [7:0] t, input logic tv);
    @(negedge clock);
    iGray = g; hs = h; vs = v; de = d; iThresh = t; iThresh_valid = tv;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic vs_pulse();
    for (int i = 0; i < 4; i++) step(8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    idle(8);
  endtask

  // Stream table entries lo..hi, checking each one 2 clocks after it is driven
  task automatic run_table(input int lo, input int hi);
    int k;
    for (int i = lo; i <= hi + 2; i++) begin
      @(negedge clock);
      if (i - 2 >= lo) begin
        k = i - 2;
        chk($sformatf("ode[%0d]", k),     32'(ode),     32'(tbl[k].de));
        chk($sformatf("obin[%0d]", k),    32'(oBin),    32'(tbl[k].exp_bin));
        chk($sformatf("ogray[%0d]", k),   32'(oGray),   tbl[k].exp_bin ? 32'hFF : 32'h00);
        chk($sformatf("obin_inv[%0d]", k), 32'(oBin_i), 32'(tbl[k].exp_inv));
        chk($sformatf("ogray_inv[%0d]", k), 32'(oGray_i), tbl[k].exp_inv ? 32'hFF : 32'h00);
      end
      if (i <= hi) begin
        iGray = tbl[i].gray; de = tbl[i].de;
      end else begin
        iGray = 8'd0; de = 1'b0;
      end
      hs = 1'b0; vs = 1'b0; iThresh_valid = 1'b0;
    end
  endtask

  // One 128x96 active frame; the first n_fg pixels are 200, the rest 100
  task automatic frame_128x96(input int n_fg);
    int p;
    p = 0;
    for (int ln = 0; ln < 96; ln++) begin
      for (int c = 0; c < 128; c++) begin
        step((p < n_fg) ? 8'd200 : 8'd100, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0);
        p++;
      end
      for (int b = 0; b < 16; b++) step(8'd0, (b < 8), 1'b0, 1'b0, 8'd0, 1'b0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_obin"},  32'(oBin),      32'd0);
    chk({tag, "_ogray"}, 32'(oGray),     32'd0);
    chk({tag, "_ohs"},   32'(ohs),       32'd0);
    chk({tag, "_ovs"},   32'(ovs),       32'd0);
    chk({tag, "_ode"},   32'(ode),       32'd0);
    chk({tag, "_cnt"},   32'(oFg_cnt),   32'd0);
    chk({tag, "_fgv"},   32'(oFg_valid), 32'd0);
    chk({tag, "_thr"},   32'(oThr_active), 32'd128);
    chk({tag, "_obin_inv"}, 32'(oBin_i), 32'd0);
    chk({tag, "_thr_inv"},  32'(oThr_active_i), 32'd128);
  endtask

  int p0;
  int p0_i;

  initial begin
    // Table: threshold 128 ramp, blanking, then per-threshold spot values
    for (int i = 0; i < 256; i++) set_tv(i, 8'(i), 1'b1, (i >= 129), (i < 129));
    set_tv(256, 8'd200, 1'b0, 1'b0, 1'b0);   // blanked, both polarities 0
    set_tv(257, 8'd0,   1'b0, 1'b0, 1'b0);
    set_tv(258, 8'd61,  1'b1, 1'b0, 1'b1);   // still thr 128 after strobe 60
    set_tv(259, 8'd61,  1'b1, 1'b1, 1'b0);   // thr 60
    set_tv(260, 8'd60,  1'b1, 1'b0, 1'b1);
    set_tv(261, 8'd59,  1'b1, 1'b0, 1'b1);
    set_tv(262, 8'd255, 1'b1, 1'b1, 1'b0);
    set_tv(263, 8'd90,  1'b1, 1'b0, 1'b1);   // thr 90
    set_tv(264, 8'd91,  1'b1, 1'b1, 1'b0);
    set_tv(265, 8'd50,  1'b1, 1'b0, 1'b1);
    set_tv(266, 8'd30,  1'b1, 1'b0, 1'b1);   // thr 30
    set_tv(267, 8'd31,  1'b1, 1'b1, 1'b0);
    set_tv(268, 8'd200, 1'b0, 1'b0, 1'b0);

    // Reset with busy inputs: everything held at reset values
    rst_n = 1'b0;
    iGray = 8'd255; hs = 1'b1; vs = 1'b1; de = 1'b1; iThresh = 8'd7; iThresh_valid = 1'b1;
    repeat (3) @(negedge clock);
    chk_all_zero("rst");
    iGray = 8'd0; hs = 1'b0; vs = 1'b0; de = 1'b0; iThresh = 8'd0; iThresh_valid = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;
    idle(3);

    // First frame after reset: no frame result
    vs_pulse();
    chk("first_ovs_no_pulse", 32'(pulses), 32'd0);
    chk("first_ovs_no_pulse_inv", 32'(pulses_i), 32'd0);
    chk("thr_default", 32'(oThr_active), 32'd128);

    // Default threshold ramp plus blanking
    run_table(0, 257);

    // Deferred update: strobe 60 mid-frame
    step(8'd10, 1'b0, 1'b0, 1'b1, 8'd60, 1'b1);
    idle(3);
    chk("thr_deferred", 32'(oThr_active), 32'd128);
    run_table(258, 258);
    vs_pulse();
    chk("thr_after_vs_60", 32'(oThr_active), 32'd60);
    run_table(259, 262);

    // Last strobe wins
    step(8'd0, 1'b0, 1'b0, 1'b0, 8'd50, 1'b1);
    idle(5);
    step(8'd0, 1'b0, 1'b0, 1'b0, 8'd90, 1'b1);
    idle(3);
    chk("thr_hold_60", 32'(oThr_active), 32'd60);
    vs_pulse();
    chk("thr_last_wins_90", 32'(oThr_active), 32'd90);
    run_table(263, 265);

    // Strobe coincident with the vs rise applies to that same frame
    step(8'd0, 1'b0, 1'b1, 1'b0, 8'd30, 1'b1);
    step(8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    chk("thr_same_cycle_30", 32'(oThr_active), 32'd30);
    step(8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    idle(6);
    run_table(266, 268);
    vs_pulse();
    chk("thr_no_stale_pending", 32'(oThr_active), 32'd30);
    chk("thr_inv_tracks", 32'(oThr_active_i), 32'd30);

    // Reset in the middle of active video with a pending strobe
    vs_pulse();
    step(8'd0, 1'b0, 1'b0, 1'b0, 8'd70, 1'b1);
    for (int i = 0; i < 20; i++) step(8'd255, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0);
    @(negedge clock);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    repeat (2) @(negedge clock);
    iGray = 8'd0; de = 1'b0;
    rst_n = 1'b1;
    idle(2);
    chk("thr_after_midrst", 32'(oThr_active), 32'd128);

    // Full frame after reset: first boundary silent, second reports the count
    p0 = pulses; p0_i = pulses_i;
    vs_pulse();
    chk("post_rst_first_ovs", 32'(pulses - p0), 32'd0);
    frame_128x96(1000);
    p0 = pulses; p0_i = pulses_i;
    vs_pulse();
    chk("frame_pulse_once", 32'(pulses - p0), 32'd1);
    chk("frame_fg_cnt", 32'(last_cnt), 32'd1000);
    chk("frame_pulse_once_inv", 32'(pulses_i - p0_i), 32'd1);
    chk("frame_fg_cnt_inv", 32'(last_cnt_i), 32'd11288);
    chk("fgv_deasserted", 32'(oFg_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
